gfx_cmd_assembler: RTL and testbench

Byte-serial command front end for the graphics engine.
- Accepts bytes strobed by the I2C slave (cmd, i2c_in_data, i2c_rts).
- Assembles each opcode's argument bytes (length depends on opcode) into one wide packet.
- Buffers complete packets in an internal FIFO and presents them to the draw engines over valid/ready.
- Generalises the single fill-rect path to multiple opcodes, configurable width/depth, backpressure and error reporting.

---
 rtl/gfx_cmd_pkg.sv | 45 ++++
 rtl/gfx_cmd_fifo.sv | 59 +++++
 rtl/gfx_cmd_assembler.sv | 165 ++++++++++++++++
 tb/tb_gfx_cmd_assembler.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gfx_cmd_pkg.sv
// rtl/gfx_cmd_pkg.sv - opcodes, argument lengths, FSM states and fill-rect field offsets
package gfx_cmd_pkg;

    localparam logic [7:0] OP_FILL_RECT = 8'd1;
    localparam logic [7:0] OP_LINE      = 8'd2;
    localparam logic [7:0] OP_PIXEL     = 8'd3;
    localparam logic [7:0] OP_CLEAR     = 8'd4;

    localparam logic [7:0] LEN_FILL_RECT = 8'd11;
    localparam logic [7:0] LEN_LINE      = 8'd9;
    localparam logic [7:0] LEN_PIXEL     = 8'd7;
    localparam logic [7:0] LEN_CLEAR     = 8'd3;

    // Byte indices within a fill-rect packet; index 0 sits in the payload MSBs.
    localparam int FR_X_HI   = 0;
    localparam int FR_X_LO   = 1;
    localparam int FR_Y_HI   = 2;
    localparam int FR_Y_LO   = 3;
    localparam int FR_WID_HI = 4;
    localparam int FR_WID_LO = 5;
    localparam int FR_HGT_HI = 6;
    localparam int FR_HGT_LO = 7;
    localparam int FR_R      = 8;
    localparam int FR_G      = 9;
    localparam int FR_B      = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PUSH    = 2'd2,
        ST_STALL   = 2'd3
    } state_t;

    // Zero marks an opcode with no table entry; the assembler treats it as invalid.
    function automatic logic [7:0] arg_len(input logic [7:0] op);
        case (op)
            OP_FILL_RECT: arg_len = LEN_FILL_RECT;
            OP_LINE:      arg_len = LEN_LINE;
            OP_PIXEL:     arg_len = LEN_PIXEL;
            OP_CLEAR:     arg_len = LEN_CLEAR;
            default:      arg_len = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/gfx_cmd_fifo.sv
// rtl/gfx_cmd_fifo.sv - synchronous show-ahead FIFO, head reads zero while empty
module gfx_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gfx_cmd_assembler.sv
// rtl/gfx_cmd_assembler.sv - byte-serial command packet assembler; CMD_TIMEOUT_EN adds inter-byte timeout
module gfx_cmd_assembler
    import gfx_cmd_pkg::*;
#(
    parameter int BYTE_W      = 8,
    parameter int MAX_ARGS    = 16,
    parameter int NUM_OPS     = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                            clk,
    input  logic                            rst_,
    input  logic [7:0]                      cmd,
    input  logic [BYTE_W-1:0]               i2c_in_data,
    input  logic                            i2c_rts,
    output logic                            i2c_busy,
    output logic                            pkt_valid,
    input  logic                            pkt_ready,
    output logic [7:0]                      pkt_op,
    output logic [$clog2(MAX_ARGS+1)-1:0]   pkt_len,
    output logic [MAX_ARGS*BYTE_W-1:0]      pkt_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            err_opcode,
`ifdef CMD_TIMEOUT_EN
    output logic                            err_timeout,
`endif
    output logic                            err_overflow
);

    localparam int LEN_W   = $clog2(MAX_ARGS + 1);
    localparam int DATA_W  = MAX_ARGS * BYTE_W;
    localparam int ENTRY_W = 8 + LEN_W + DATA_W;

    state_t              state;
    logic [7:0]          cur_op;
    logic [LEN_W-1:0]    cur_len;
    logic [LEN_W-1:0]    cnt;
    logic [LEN_W-1:0]    cnt_nxt;
    logic [LEN_W-1:0]    new_len;
    logic [DATA_W-1:0]   pkt_buf;
    logic                cmd_ok;
    logic                start_new;
    logic                pop;
    logic                push_ok;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  head;

    assign new_len = LEN_W'(arg_len(cmd));
    assign cmd_ok  = (cmd != 8'd0) && (int'(cmd) <= NUM_OPS) && (new_len != '0);
    assign cnt_nxt = cnt + LEN_W'(1);
    assign pop     = pkt_valid && pkt_ready;
    assign push_ok = ((state == ST_PUSH) || (state == ST_STALL)) && (!fifo_full || pop);

    // An opcode switch mid-packet restarts assembly with the switching byte as byte 0.
    assign start_new = i2c_rts && cmd_ok &&
                       ((state == ST_IDLE) || ((state == ST_COLLECT) && (cmd != cur_op)));

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle_cnt;
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state        <= ST_IDLE;
            cur_op       <= '0;
            cur_len      <= '0;
            cnt          <= '0;
            pkt_buf      <= '0;
            i2c_busy     <= 1'b0;
            err_opcode   <= 1'b0;
            err_overflow <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            idle_cnt     <= '0;
            err_timeout  <= 1'b0;
`endif
        end else begin
            err_opcode   <= 1'b0;
            err_overflow <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            err_timeout  <= 1'b0;
            idle_cnt     <= '0;
`endif
            case (state)
                ST_IDLE: begin
                    if (i2c_rts && !cmd_ok) begin
                        err_opcode <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (i2c_rts) begin
                        if (cmd == cur_op) begin
                            pkt_buf[(MAX_ARGS-1-int'(cnt))*BYTE_W +: BYTE_W] <= i2c_in_data;
                            cnt <= cnt_nxt;
                            if (cnt_nxt == cur_len) begin
                                state <= ST_PUSH;
                            end
                        end else begin
                            err_opcode <= 1'b1;
                            if (!cmd_ok) begin
                                state <= ST_IDLE;
                            end
                        end
                    end
`ifdef CMD_TIMEOUT_EN
                    else if (idle_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        state       <= ST_IDLE;
                        err_timeout <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + TO_W'(1);
                    end
`endif
                end
                ST_PUSH: begin
                    if (push_ok) begin
                        state <= ST_IDLE;
                    end else begin
                        state    <= ST_STALL;
                        i2c_busy <= 1'b1;
                    end
                    if (i2c_rts) begin
                        err_overflow <= 1'b1;
                    end
                end
                default: begin
                    if (push_ok) begin
                        state    <= ST_IDLE;
                        i2c_busy <= 1'b0;
                    end
                    if (i2c_rts) begin
                        err_overflow <= 1'b1;
                    end
                end
            endcase

            if (start_new) begin
                cur_op  <= cmd;
                cur_len <= new_len;
                cnt     <= LEN_W'(1);
                pkt_buf <= {i2c_in_data, {(DATA_W-BYTE_W){1'b0}}};
                state   <= (new_len == LEN_W'(1)) ? ST_PUSH : ST_COLLECT;
            end
        end
    end

    gfx_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_),
        .push    (push_ok),
        .wr_data ({cur_op, cur_len, pkt_buf}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign pkt_valid = !fifo_empty;
    assign {pkt_op, pkt_len, pkt_data} = head;

endmodule

// File: tb/tb_gfx_cmd_assembler.sv
// tb/tb_gfx_cmd_assembler.sv - directed self-checking bench for gfx_cmd_assembler
module tb_gfx_cmd_assembler;
    import gfx_cmd_pkg::*;

`ifdef CMD_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 4096;
`endif

    logic         clk = 1'b0;
    logic         rst_ = 1'b0;
    logic [7:0]   cmd = '0;
    logic [7:0]   i2c_in_data = '0;
    logic         i2c_rts = 1'b0;
    logic         i2c_busy;
    logic         pkt_valid;
    logic         pkt_ready = 1'b0;
    logic [7:0]   pkt_op;
    logic [4:0]   pkt_len;
    logic [127:0] pkt_data;
    logic [2:0]   fifo_count;
    logic         err_opcode;
    logic         err_overflow;
`ifdef CMD_TIMEOUT_EN
    logic         err_timeout;
`endif

    int tests = 0;
    int fails = 0;

    gfx_cmd_assembler #(
        .BYTE_W      (8),
        .MAX_ARGS    (16),
        .NUM_OPS     (4),
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk          (clk),
        .rst_         (rst_),
        .cmd          (cmd),
        .i2c_in_data  (i2c_in_data),
        .i2c_rts      (i2c_rts),
        .i2c_busy     (i2c_busy),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .pkt_op       (pkt_op),
        .pkt_len      (pkt_len),
        .pkt_data     (pkt_data),
        .fifo_count   (fifo_count),
        .err_opcode   (err_opcode),
`ifdef CMD_TIMEOUT_EN
        .err_timeout  (err_timeout),
`endif
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe one byte for exactly one rising edge; returns on the following falling edge.
    task automatic send_byte(input logic [7:0] c, input logic [7:0] d);
        @(negedge clk);
        cmd         = c;
        i2c_in_data = d;
        i2c_rts     = 1'b1;
        @(negedge clk);
        i2c_rts     = 1'b0;
    endtask

    task automatic pop_one();
        pkt_ready = 1'b1;
        @(negedge clk);
        pkt_ready = 1'b0;
    endtask

    logic [7:0]   fr_a [11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 8'h0F, 8'h00, 8'h00};
    logic [7:0]   fr_b [11] = '{8'h01, 8'h23, 8'h00, 8'h45, 8'h00, 8'h10, 8'h00, 8'h20, 8'hFF, 8'h80, 8'h01};
    logic [127:0] exp_clr;

    initial begin
        repeat (2) @(negedge clk);
        check("reset_valid", pkt_valid, 0);
        check("reset_count", fifo_count, 0);
        check("reset_busy", i2c_busy, 0);
        check("reset_data", pkt_data, 0);
        rst_ = 1'b1;

        // fill-rect with engine ready: valid two cycles after the last strobe
        pkt_ready = 1'b1;
        foreach (fr_a[i]) send_byte(OP_FILL_RECT, fr_a[i]);
        check("fr_valid_early", pkt_valid, 0);
        @(negedge clk);
        check("fr_valid", pkt_valid, 1);
        check("fr_op", pkt_op, 1);
        check("fr_len", pkt_len, 11);
        check("fr_data", pkt_data, 128'h00000000_02000200_0F000000_00000000);
        check("fr_field_r", pkt_data[(15-FR_R)*8 +: 8], 8'h0F);
        check("fr_field_wid_hi", pkt_data[(15-FR_WID_HI)*8 +: 8], 8'h02);
        @(negedge clk);
        check("fr_popped_count", fifo_count, 0);
        check("fr_popped_valid", pkt_valid, 0);
        pkt_ready = 1'b0;

        // five clear packets into a four-deep FIFO
        for (int k = 1; k <= 5; k++) begin
            send_byte(OP_CLEAR, 8'(k));
            send_byte(OP_CLEAR, 8'(8'hA0 + k));
            send_byte(OP_CLEAR, 8'(8'hB0 + k));
            if (k == 4) begin
                @(negedge clk);
                check("bp_count4", fifo_count, 4);
                check("bp_busy_before", i2c_busy, 0);
            end
        end
        @(negedge clk);
        check("bp_busy", i2c_busy, 1);
        check("bp_count_full", fifo_count, 4);
        send_byte(OP_CLEAR, 8'h66);
        check("bp_overflow", err_overflow, 1);
        @(negedge clk);
        check("bp_overflow_clear", err_overflow, 0);
        check("bp_busy_hold", i2c_busy, 1);
        for (int k = 1; k <= 5; k++) begin
            exp_clr = {8'(k), 8'(8'hA0 + k), 8'(8'hB0 + k), 104'h0};
            check($sformatf("drain_op_%0d", k), pkt_op, OP_CLEAR);
            check($sformatf("drain_len_%0d", k), pkt_len, 3);
            check($sformatf("drain_data_%0d", k), pkt_data, exp_clr);
            pop_one();
            if (k == 1) begin
                check("bp_count_after_pop", fifo_count, 4);
                check("bp_busy_released", i2c_busy, 0);
            end
        end
        check("drain_empty", pkt_valid, 0);

        // invalid opcode is dropped
        send_byte(8'h07, 8'h55);
        check("badop_err", err_opcode, 1);
        @(negedge clk);
        check("badop_err_pulse", err_opcode, 0);
        check("badop_count", fifo_count, 0);

        // opcode switch mid-packet restarts with the switching byte
        for (int i = 0; i < 4; i++) send_byte(OP_LINE, 8'(8'h20 + i));
        send_byte(OP_PIXEL, 8'h30);
        check("switch_err", err_opcode, 1);
        for (int i = 1; i < 7; i++) send_byte(OP_PIXEL, 8'(8'h30 + i));
        @(negedge clk);
        check("switch_count", fifo_count, 1);
        check("switch_op", pkt_op, OP_PIXEL);
        check("switch_len", pkt_len, 7);
        check("switch_data", pkt_data, 128'h30313233_34353600_00000000_00000000);
        pop_one();
        check("switch_drained", fifo_count, 0);

        // asynchronous reset with two queued packets and a partial fill-rect
        send_byte(OP_CLEAR, 8'h01); send_byte(OP_CLEAR, 8'h02); send_byte(OP_CLEAR, 8'h03);
        send_byte(OP_CLEAR, 8'h04); send_byte(OP_CLEAR, 8'h05); send_byte(OP_CLEAR, 8'h06);
        for (int i = 0; i < 5; i++) send_byte(OP_FILL_RECT, fr_b[i]);
        check("rst_pre_count", fifo_count, 2);
        #2 rst_ = 1'b0;
        #1;
        check("rst_async_count", fifo_count, 0);
        check("rst_async_valid", pkt_valid, 0);
        check("rst_async_op", pkt_op, 0);
        check("rst_async_len", pkt_len, 0);
        check("rst_async_data", pkt_data, 0);
        check("rst_async_busy", i2c_busy, 0);
        check("rst_async_errs", {err_opcode, err_overflow}, 0);
        @(negedge clk);
        rst_ = 1'b1;
        foreach (fr_b[i]) send_byte(OP_FILL_RECT, fr_b[i]);
        @(negedge clk);
        check("post_rst_count", fifo_count, 1);
        check("post_rst_op", pkt_op, OP_FILL_RECT);
        check("post_rst_len", pkt_len, 11);
        check("post_rst_data", pkt_data, 128'h01230045_00100020_FF800100_00000000);
        pop_one();

`ifdef CMD_TIMEOUT_EN
        send_byte(OP_FILL_RECT, 8'h11); send_byte(OP_FILL_RECT, 8'h22); send_byte(OP_FILL_RECT, 8'h33);
        repeat (15) @(negedge clk);
        check("to_not_yet", err_timeout, 0);
        @(negedge clk);
        check("to_pulse", err_timeout, 1);
        @(negedge clk);
        check("to_pulse_end", err_timeout, 0);
        check("to_no_packet", fifo_count, 0);
        send_byte(OP_CLEAR, 8'hC1); send_byte(OP_CLEAR, 8'hC2); send_byte(OP_CLEAR, 8'hC3);
        @(negedge clk);
        check("to_next_op", pkt_op, OP_CLEAR);
        check("to_next_data", pkt_data, {8'hC1, 8'hC2, 8'hC3, 104'h0});
        pop_one();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
